// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//   Shift-and-add multiplier controller that borrows the shared ALU to
//   compute the low WIDTH bits of op_a * op_b. While idle (and in the
//   single DONE cycle) the datapath's ALU operands pass straight through.
//   While a multiply runs, the sequencer drives the ALU with ADD operations
//   and raises busy so the pipeline stalls.
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   start, op_a, op_b     multiply request; sampled only in IDLE
//   busy                  high while the sequencer owns the ALU (RUN)
//   done                  one-cycle pulse; product is valid
//   product               registered result, held until the next result
//   dp_A, dp_B, dp_cntrl  datapath ALU request (pass-through source)
//   alu_A, alu_B, alu_cntrl  to the shared ALU
//   alu_result            combinational result from the shared ALU
module alu_mul_sequencer #(
    parameter int         WIDTH     = 64,
    parameter logic [2:0] ADD_CNTRL = 3'b010
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    input  logic [WIDTH-1:0] dp_A,
    input  logic [WIDTH-1:0] dp_B,
    input  logic [2:0]       dp_cntrl,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] acc, mcand, mplier;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic and outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        alu_A      = dp_A;
        alu_B      = dp_B;
        alu_cntrl  = dp_cntrl;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy      = 1'b1;
                alu_A     = acc;
                alu_B     = mcand;
                alu_cntrl = ADD_CNTRL;
                // Loop ends as soon as no multiplier bits remain, so the
                // step count follows the highest set bit of op_b.
                if (mplier == '0) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Multiply datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mcand  <= op_a;
                    mplier <= op_b;
                    acc    <= '0;
                end
                RUN: begin
                    if (mplier == '0) begin
                        product <= acc;
                    end else begin
                        // alu_result is acc + mcand; carry/overflow dropped,
                        // so the result is the product mod 2^WIDTH.
                        if (mplier[0]) acc <= alu_result;
                        mcand  <= {mcand[WIDTH-2:0], 1'b0};
                        mplier <= {1'b0, mplier[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle shift-and-add multiplier controller that borrows the shared 64-bit ALU to compute MUL (low 64 bits of A*B) for the LEGv8 datapath.
- When idle, the block passes the datapath's ALU operands and control straight through.
- While a multiply runs, it takes ownership of the ALU, drives ADD operations, and holds the pipeline stalled via busy.

Parameters:
- WIDTH, 64, operand/product width.
- ADD_CNTRL, 3'b010, ALU cntrl encoding for add.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- op_a  input  WIDTH  multiplicand.
- op_b  input  WIDTH  multiplier.
- busy  output  1  high in RUN; pipeline stall.
- done  output  1  one-cycle pulse; product valid.
- product  output  WIDTH  registered result; holds until next accepted start.
- dp_A  input  WIDTH  datapath ALU operand A.
- dp_B  input  WIDTH  datapath ALU operand B.
- dp_cntrl  input  3  datapath ALU control.
- alu_A  output  WIDTH  to shared ALU A.
- alu_B  output  WIDTH  to shared ALU B.
- alu_cntrl  output  3  to shared ALU cntrl.
- alu_result  input  WIDTH  combinational result from shared ALU.

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE.
  - acc, mcand, mplier, product = 0.
  - busy=0, done=0.
  - Takes effect immediately, including mid-RUN; any partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - ALU outputs are a combinational pass-through: alu_A=dp_A, alu_B=dp_B, alu_cntrl=dp_cntrl.
  - On an edge with start=1: mcand<=op_a, mplier<=op_b, acc<=0, state->RUN.
- RUN:
  - ALU outputs driven by the sequencer: alu_A=acc, alu_B=mcand, alu_cntrl=ADD_CNTRL. dp_* are ignored.
  - Each edge, if mplier==0: product<=acc, state->DONE, no step.
  - Otherwise one step:
    - If mplier[0]=1, acc<=alu_result; else acc unchanged.
    - mcand<=mcand<<1, discarding the MSB.
    - mplier<=mplier>>1, logical shift.
  - The ALU's carry_out/overflow flags are ignored; arithmetic is mod 2^WIDTH. Signed and unsigned operands therefore give identical low-word results.
- DONE:
  - done=1 for exactly one cycle; ALU is back in pass-through.
  - Next edge: state->IDLE, done->0.
  - start is ignored in DONE; it is accepted on the following IDLE edge.
- busy=1 only in RUN. start while busy (RUN or DONE) is ignored, with no queuing.
- Latency, counted from the edge that samples start to the edge after which done is high:
  - L = msb(op_b)+2, where msb is the 0-based index of the highest set bit.
  - op_b=0 gives L=1.
  - Maximum is 65 (op_b[63]=1).
- Early termination: the loop ends as soon as mplier==0. No iteration counter exists; at most WIDTH steps occur.
- Operands: op_a/op_b need only be valid on the start edge; later changes have no effect.
- product changes only on the RUN->DONE transition and on reset.

Test Plan:
- Pass-through:
  - Stimulus: idle; dp_A=5, dp_B=3, dp_cntrl=3'b011.
  - Required: alu_A=5, alu_B=3, alu_cntrl=3'b011 in the same cycle; busy=0.
- Basic multiply:
  - Stimulus: op_a=6, op_b=7, start pulse.
  - Required: busy high for 4 cycles; done pulses once 4 edges after start; product=42; alu_cntrl=3'b010 throughout RUN.
- Zero multiplier:
  - Stimulus: op_a=0x1234, op_b=0, start.
  - Required: done 1 edge after start; product=0.
- Negative operand:
  - Stimulus: op_a=0xFFFFFFFFFFFFFFFD (-3), op_b=5.
  - Required: product=0xFFFFFFFFFFFFFFF1 (-15); L=4.
- Worst case:
  - Stimulus: op_a=1, op_b=0x8000000000000000.
  - Required: L=65; product=0x8000000000000000.
  - Second stimulus: op_a=3, op_b=0x8000000000000000.
  - Required: product=0x8000000000000000 (overflow wraps).
- Start during busy, then reset mid-operation:
  - Stimulus: re-assert start with new operands mid-RUN.
  - Required: result unchanged; only one done pulse.
  - Stimulus: drop reset_n mid-RUN.
  - Required: busy, done and product go to 0 immediately; pass-through resumes.
  - Stimulus: a new start after reset release.
  - Required: a correct product.
